// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and constants for the reset sequencer.
//   state_t       - sequencer state encoding
//   LOSS_CNT_W    - width of the lock-loss event counter
//   LOSS_CNT_MAX  - saturation value of the lock-loss event counter
//   max_int       - helper used to size the shared cycle counter
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    PERIPH    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears both flops to 0
//   d    - asynchronous input
//   q    - synchronized output (two clk edges of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// rst_seq: staged reset sequencer for the 100 MHz domain. Waits for a stable
// MMCM lock, releases peripheral reset, then CPU reset. Loss of lock or a
// (debounced) button press restarts the whole sequence.
// Optional feature: define RST_SEQ_BTN_DEBOUNCE_EN to compile in the
// pushbutton synchronizer and debouncer; otherwise btn_rst is ignored.
// Ports:
//   clk           - 100 MHz system clock
//   rst           - asynchronous active-high external reset
//   locked        - MMCM lock status (asynchronous)
//   btn_rst       - raw pushbutton, active-high (asynchronous, bouncing)
//   periph_rst    - active-high peripheral reset (registered)
//   cpu_rst       - active-high CPU reset (registered)
//   ready         - high once both resets are released
//   lock_loss_cnt - saturating count of lock-loss aborts
//
// state     | meaning
// WAIT_LOCK | both resets held, waiting for lock and no button
// STABLE    | lock seen, counting LOCK_STABLE_CYCLES of continuous lock
// PERIPH    | peripheral reset released, counting PERIPH_HOLD_CYCLES
// RUN       | all resets released
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int PERIPH_HOLD_CYCLES = 16,
  parameter int DEBOUNCE_CYCLES    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  btn_rst,
  output logic                  periph_rst,
  output logic                  cpu_rst,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

`ifdef RST_SEQ_BTN_DEBOUNCE_EN
  localparam int CNT_MAX = max_int(max_int(LOCK_STABLE_CYCLES, PERIPH_HOLD_CYCLES), DEBOUNCE_CYCLES);
`else
  localparam int CNT_MAX = max_int(LOCK_STABLE_CYCLES, PERIPH_HOLD_CYCLES);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PERIPH_HOLD_CYCLES - 1);

  logic locked_s;
  logic btn_db;

  sync_2ff u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

`ifdef RST_SEQ_BTN_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s;
  logic [CNT_W-1:0] db_cnt;

  sync_2ff u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d   (btn_rst),
    .q   (btn_s)
  );

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive samples
  // that disagree with it; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      btn_db <= btn_s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = DEBOUNCE_CYCLES ^ {31'd0, btn_rst};
  assign btn_db     = 1'b0;
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             loss_inc;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    loss_inc   = 1'b0;
    if (state == WAIT_LOCK) begin
      cnt_next = '0;
      if (locked_s && !btn_db) state_next = STABLE;
    end else if (!locked_s || btn_db) begin
      // Abort wins over count completion on the same edge.
      state_next = WAIT_LOCK;
      cnt_next   = '0;
      loss_inc   = !locked_s;
    end else begin
      case (state)
        STABLE: begin
          if (cnt == LOCK_LAST) begin
            state_next = PERIPH;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        PERIPH: begin
          if (cnt == HOLD_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register, with no combinational path to the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      periph_rst    <= 1'b1;
      cpu_rst       <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      periph_rst <= !(state_next == PERIPH || state_next == RUN);
      cpu_rst    <= (state_next != RUN);
      ready      <= (state_next == RUN);
      if (loss_inc && lock_loss_cnt != LOSS_CNT_MAX)
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer sitting directly downstream of the board clock generator: it consumes the MMCM `locked` status and an optional pushbutton, and produces staged, clock-synchronous resets for the 100 MHz domain. It waits for a stable lock, then releases peripheral reset before CPU reset, so memories and I/O are out of reset before the pipeline fetches. Any loss of lock, or a button press, re-enters the full sequence.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles `locked` must stay high before peripheral release (≥1).
- `PERIPH_HOLD_CYCLES`, 16: cycles between peripheral release and CPU release (≥1).
- `DEBOUNCE_CYCLES`, 1000000: consecutive equal samples required to change debounced button state (10 ms at 100 MHz).
- `clk` input 1: 100 MHz system clock (the generator's `clk_100m`).
- `rst` input 1: external reset; asynchronous, active-high.
- `locked` input 1: MMCM lock; asynchronous to `clk`.
- `btn_rst` input 1: raw pushbutton, active-high, asynchronous, bouncing.
- `periph_rst` output 1: active-high peripheral reset.
- `cpu_rst` output 1: active-high CPU reset.
- `ready` output 1: high when both resets released.
- `lock_loss_cnt` output 8: saturating count of lock-loss events.

## Operation
- Reset values (while `rst`=1): `periph_rst`=1, `cpu_rst`=1, `ready`=0, `lock_loss_cnt`=0, state=WAIT_LOCK, counter=0, synchronizers and debouncer cleared to 0.
- `locked` and `btn_rst` each pass a two-flop synchronizer → `locked_s`, `btn_s`.
- States:
  - WAIT_LOCK: resets asserted; → STABLE when `locked_s`=1 and `btn_db`=0, counter←0.
  - STABLE: counter increments; when counter = LOCK_STABLE_CYCLES−1 → PERIPH, counter←0.
  - PERIPH: `periph_rst`=0; counter increments; when counter = PERIPH_HOLD_CYCLES−1 → RUN.
  - RUN: `periph_rst`=0, `cpu_rst`=0, `ready`=1; remains until abort.
- Abort: `locked_s`=0 or `btn_db`=1 in STABLE/PERIPH/RUN → WAIT_LOCK on that edge, counter←0, both resets asserted and `ready`←0 on the same edge. Abort has priority over count completion.
- `lock_loss_cnt` increments on each abort caused by `locked_s`=0 (not button) from STABLE/PERIPH/RUN; saturates at 255; cleared only by `rst`.
- Outputs are registered; no glitches; deassertion always synchronous to `clk`, assertion via `rst` asynchronous.
- Counter width = clog2 of max(LOCK_STABLE_CYCLES, PERIPH_HOLD_CYCLES, DEBOUNCE_CYCLES)+1; never wraps.

## Timing
- `locked` high before edge 1 and held: `locked_s`=1 after edge 2; STABLE entered at edge 3; `periph_rst` falls at edge 3+LOCK_STABLE_CYCLES; `cpu_rst` falls and `ready` rises at edge 3+LOCK_STABLE_CYCLES+PERIPH_HOLD_CYCLES (defaults: 1027, 1043).
- `locked` falling: resets assert 3 edges later (2 sync + 1 state).
- Debounced button changes state after DEBOUNCE_CYCLES consecutive equal `btn_s` samples; any differing sample restarts its counter.
- `rst` asserted mid-sequence: all outputs to reset values immediately, asynchronously.

## Configuration
- `RST_SEQ_BTN_DEBOUNCE_EN` defined: synchronizer + debouncer on `btn_rst` compiled in, behaviour as above.
- Not defined: `btn_db` tied 0, `btn_rst` ignored, no debounce counter synthesized; `DEBOUNCE_CYCLES` excluded from counter-width calculation.

## Structure
- Package `rst_seq_pkg`: state encoding (WAIT_LOCK=0, STABLE=1, PERIPH=2, RUN=3), lock-loss counter width (8) and saturation value.
- Sub-module `sync_2ff`: two-flop synchronizer, async active-high reset to 0; instantiated for `locked` and (when enabled) `btn_rst`.

## Test plan
- `rst` 1→0, `locked` high from edge 1 → `periph_rst` low after edge 1027, `cpu_rst` low and `ready` high after edge 1043, `lock_loss_cnt`=0.
- In RUN, `locked` low for 1 cycle → resets asserted 3 edges later, `lock_loss_cnt`=1, full 1024+16 sequence restarts.
- `locked` dropped at STABLE count 1023 (completion edge) → stays WAIT_LOCK, `periph_rst` never deasserts.
- 300 lock-loss events → `lock_loss_cnt` saturates at 255.
- (EN, DEBOUNCE_CYCLES=8) `btn_rst` bounces 1/0 every 3 cycles then high 8 cycles → abort only after stable run; counter unchanged; release 8 low cycles then sequence restarts.
- `rst` pulsed in PERIPH → outputs return to reset values without waiting for `clk`.
